// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters (A = CPU, B = loader), the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  req_a, req_b;
  logic                  we_a, we_b;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [DATA_WIDTH-1:0] wdata_a, wdata_b;
  logic                  ack_a, ack_b;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
  logic                  ram_write;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic                  busy;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, ram_data_out,
    output ack_a, ack_b, rdata_a, rdata_b, ram_write, ram_address, ram_data_in, busy
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, ram_data_out,
    input  ack_a, ack_b, rdata_a, rdata_b, ram_write, ram_address, ram_data_in, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for an asynchronous strobe-written RAM; every output is registered.
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration, otherwise A has fixed priority.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  ram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_STROBE, WR_HOLD, ACK} state_t;

  state_t                r_state, w_state;
  logic                  r_gnt_b, w_gnt_b;
  logic                  r_last_b, w_last_b;
  logic                  r_ram_write, w_ram_write;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic [DATA_WIDTH-1:0] r_rdata_a, w_rdata_a;
  logic [DATA_WIDTH-1:0] r_rdata_b, w_rdata_b;
  logic                  r_ack_a, w_ack_a;
  logic                  r_ack_b, w_ack_b;
  logic                  r_busy, w_busy;
  logic                  w_pick_b;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  // On contention favour whoever was not granted last.
  assign w_pick_b = bus.req_b & (~bus.req_a | ~r_last_b);
`else
  assign w_pick_b = bus.req_b & ~bus.req_a;
`endif

  always_comb begin
    w_state     = r_state;
    w_gnt_b     = r_gnt_b;
    w_last_b    = r_last_b;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_rdata_a   = r_rdata_a;
    w_rdata_b   = r_rdata_b;
    w_ram_write = 1'b0;
    w_ack_a     = 1'b0;
    w_ack_b     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_a | bus.req_b) begin
          w_gnt_b  = w_pick_b;
          w_last_b = w_pick_b;
          w_addr   = w_pick_b ? bus.addr_b  : bus.addr_a;
          w_wdata  = w_pick_b ? bus.wdata_b : bus.wdata_a;
          w_state  = (w_pick_b ? bus.we_b : bus.we_a) ? WR_SETUP : RD;
        end
      end
      RD: begin
        w_state = ACK;
        if (r_gnt_b) w_rdata_b = bus.ram_data_out;
        else         w_rdata_a = bus.ram_data_out;
        w_ack_a = ~r_gnt_b;
        w_ack_b = r_gnt_b;
      end
      // Strobe rises one cycle after address/data settle and falls one cycle before they may move.
      WR_SETUP: begin
        w_state     = WR_STROBE;
        w_ram_write = 1'b1;
      end
      WR_STROBE: w_state = WR_HOLD;
      WR_HOLD: begin
        w_state = ACK;
        w_ack_a = ~r_gnt_b;
        w_ack_b = r_gnt_b;
      end
      ACK:     w_state = IDLE;
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt_b     <= 1'b0;
      r_last_b    <= 1'b1;
      r_ram_write <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata_a   <= '0;
      r_rdata_b   <= '0;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_gnt_b     <= w_gnt_b;
      r_last_b    <= w_last_b;
      r_ram_write <= w_ram_write;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_rdata_a   <= w_rdata_a;
      r_rdata_b   <= w_rdata_b;
      r_ack_a     <= w_ack_a;
      r_ack_b     <= w_ack_b;
      r_busy      <= w_busy;
    end
  end

  assign bus.ram_write   = r_ram_write;
  assign bus.ram_address = r_addr;
  assign bus.ram_data_in = r_wdata;
  assign bus.rdata_a     = r_rdata_a;
  assign bus.rdata_b     = r_rdata_b;
  assign bus.ack_a       = r_ack_a;
  assign bus.ack_b       = r_ack_b;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected acks, a negedge monitor pops them.
// A behavioural RAM writes on the rising edge of ram_write and reads combinationally.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt = 0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] mem [256];
  bit   busy_hist [int];

  typedef struct {
    bit         b;
    bit         rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb [$];

  ram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.ram_data_out = mem[bus.ram_address];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
    mem[8'h20] = 8'h33;
    forever begin
      @(posedge bus.ram_write);
      mem[bus.ram_address] = bus.ram_data_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    busy_hist[cyc] = bus.busy;
    if (bus.ram_write) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.ram_address;
      wr_data <= bus.ram_data_in;
    end
    if (rst_n && (bus.ack_a || bus.ack_b)) begin
      chk("ack_exclusive", 32'(bus.ack_a & bus.ack_b), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, bus.ack_a, bus.ack_b}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_who_b", 32'(bus.ack_b), 32'(e.b));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.rd) chk(e.b ? "rdata_b" : "rdata_a", 32'(e.b ? bus.rdata_b : bus.rdata_a), 32'(e.data));
      end
    end
  end

  task automatic drive(input bit b, input bit req, input bit we, input logic [7:0] addr, input logic [7:0] data);
    if (b) begin bus.req_b = req; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = data; end
    else   begin bus.req_a = req; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = data; end
  endtask

  task automatic wait_ack(input bit b, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (b ? bus.ack_b : bus.ack_a) seen = 1'b1;
    end
    if (!seen) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  // One isolated transaction; expected ack cycle counts from the cycle req is presented in IDLE.
  task automatic do_req(input bit b, input bit we, input logic [7:0] addr, input logic [7:0] data,
                        input logic [7:0] exp_rd);
    int t;
    @(posedge clk); #1;
    t = cyc;
    drive(b, 1'b1, we, addr, data);
    sb.push_back('{b: b, rd: !we, data: exp_rd, cyc: t + (we ? 4 : 2)});
    wait_ack(b, 10);
    @(posedge clk); #1;
    drive(b, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  function automatic logic [31:0] all_outs();
    return {7'd0, bus.ram_write, bus.ack_a, bus.ack_b, bus.busy, 5'd0,
            bus.ram_address | bus.ram_data_in | bus.rdata_a | bus.rdata_b};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int w0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    repeat (2) @(negedge clk);
    chk("rst_ram_write",   32'(bus.ram_write),   32'd0);
    chk("rst_ram_address", 32'(bus.ram_address), 32'd0);
    chk("rst_ram_data_in", 32'(bus.ram_data_in), 32'd0);
    chk("rst_acks",        {bus.ack_a, bus.ack_b}, 32'd0);
    chk("rst_rdata_a",     32'(bus.rdata_a),     32'd0);
    chk("rst_rdata_b",     32'(bus.rdata_b),     32'd0);
    chk("rst_busy",        32'(bus.busy),        32'd0);
    rst_n = 1'b1;

    // B writes 0x10 <- 0x5A
    w0 = wr_cnt;
    do_req(1'b1, 1'b1, 8'h10, 8'h5A, 8'h00);
    chk("wr_pulse_count", 32'(wr_cnt - w0), 32'd1);
    chk("wr_pulse_addr",  32'(wr_addr),     32'h10);
    chk("wr_pulse_data",  32'(wr_data),     32'h5A);
    chk("mem_10",         32'(mem[8'h10]),  32'h5A);

    // A reads it back
    do_req(1'b0, 1'b0, 8'h10, 8'h00, 8'h5A);

    // Reset while in WR_SETUP: nothing must reach the RAM
    w0 = wr_cnt;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 8'h20, 8'hFF);
    @(posedge clk);
    @(negedge clk);
    chk("setup_busy",  32'(bus.busy),      32'd1);
    chk("setup_no_wr", 32'(bus.ram_write), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_setup_outs", all_outs(), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_setup_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("rst_setup_mem20", 32'(mem[8'h20]),  32'h33);

    // Reset while in WR_STROBE: strobe drops at once, the write stands
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 8'h20, 8'hFF);
    @(posedge clk);
    @(posedge clk); #1;
    chk("strobe_high", 32'(bus.ram_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_strobe_outs",  all_outs(),      32'd0);
    chk("rst_strobe_mem20", 32'(mem[8'h20]), 32'hFF);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_strobe_no_ack", 32'(sb.size()), 32'd0);

    // Contention: both read and hold req for four transactions
    @(posedge clk); #1;
    t = cyc;
    drive(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    sb.push_back('{b: 1'b0, rd: 1'b1, data: 8'hA1, cyc: t + 2});
    sb.push_back('{b: 1'b1, rd: 1'b1, data: 8'hA2, cyc: t + 5});
    sb.push_back('{b: 1'b0, rd: 1'b1, data: 8'hA1, cyc: t + 8});
    sb.push_back('{b: 1'b1, rd: 1'b1, data: 8'hA2, cyc: t + 11});
`else
    for (int k = 0; k < 4; k++) sb.push_back('{b: 1'b0, rd: 1'b1, data: 8'hA1, cyc: t + 2 + 3 * k});
`endif
    repeat (12) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    chk("contention_drained", 32'(sb.size()), 32'd0);

    // A back-to-back reads of 0x00..0x03 with req held, address advanced after each ack
    @(posedge clk); #1;
    t = cyc;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) sb.push_back('{b: 1'b0, rd: 1'b1, data: 8'hA0 + 8'(k), cyc: t + 2 + 3 * k});
    for (int k = 1; k < 4; k++) begin
      repeat (3) @(posedge clk);
      #1;
      bus.addr_a = 8'(k);
    end
    repeat (3) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    chk("b2b_drained", 32'(sb.size()), 32'd0);
    for (int k = 1; k < 12; k++)
      chk($sformatf("b2b_busy_%0d", k), 32'(busy_hist[t + k]), (k % 3 == 0) ? 32'd0 : 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
